// File: rtl/game_pkg.sv
// Shared constants, types and bus field helpers for the obstacle/collision logic.
package game_pkg;

   localparam int NUM_OBSTACLES = 10;
   localparam int SCREEN_WIDTH  = 640;
   localparam int UPPER_BOUND   = 20;
   localparam int LOWER_BOUND   = 460;
   localparam int PLAYER_X      = 80;
   localparam int PLAYER_SIZE_X = 40;
   localparam int PLAYER_SIZE_Y = 40;
   localparam int OFFSCREEN_X   = 700;
   localparam int OFFSCREEN_Y   = 500;

   localparam logic [3:0] HIT_BOUNDARY = 4'hF;

   typedef enum logic [1:0] {GM_IDLE = 2'b00, GM_RUN = 2'b01} gamemode_t;
   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_REPORT} state_t;

   function automatic logic [9:0] get_left(input logic [19:0] x);
      return x[19:10];
   endfunction

   function automatic logic [9:0] get_right(input logic [19:0] x);
      return x[9:0];
   endfunction

   function automatic logic [8:0] get_top(input logic [17:0] y);
      return y[17:9];
   endfunction

   function automatic logic [8:0] get_bottom(input logic [17:0] y);
      return y[8:0];
   endfunction

endpackage

// File: rtl/collision_detector_if.sv
// Frame-tick scan request, obstacle bus and crash report between game logic and detector.
interface collision_detector_if;
   import game_pkg::*;

   logic [1:0]                          gamemode;
   logic                                start;
   logic [NUM_OBSTACLES-1:0][19:0]      obstacle_x;
   logic [NUM_OBSTACLES-1:0][17:0]      obstacle_y;
   logic [8:0]                          player_y;
   logic                                busy;
   logic                                done;
   logic                                crash;
   logic [3:0]                          hit_index;

   modport master (output gamemode, start, obstacle_x, obstacle_y, player_y,
                   input  busy, done, crash, hit_index);
   modport slave  (input  gamemode, start, obstacle_x, obstacle_y, player_y,
                   output busy, done, crash, hit_index);
endinterface

// File: rtl/rect_overlap.sv
// Strict rectangle overlap: touching edges do not count as a hit.
module rect_overlap (
   input  logic [10:0] a_l_i,
   input  logic [10:0] a_r_i,
   input  logic [10:0] a_t_i,
   input  logic [10:0] a_b_i,
   input  logic [10:0] b_l_i,
   input  logic [10:0] b_r_i,
   input  logic [10:0] b_t_i,
   input  logic [10:0] b_b_i,
   output logic        hit_o
);
   assign hit_o = (a_l_i < b_r_i) && (a_r_i > b_l_i) &&
                  (a_t_i < b_b_i) && (a_b_i > b_t_i);
endmodule

// File: rtl/collision_detector.sv
// Snapshots the obstacle bus on a frame tick, scans one slot per cycle, and
// raises a sticky crash flag with the lowest offending slot (0xF = play-area boundary).
module collision_detector
   import game_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   collision_detector_if.slave  bus
);

   state_t                          state_q, state_d;
   logic [NUM_OBSTACLES-1:0][19:0]  snap_x_q;
   logic [NUM_OBSTACLES-1:0][17:0]  snap_y_q;
   logic [8:0]                      py_q;
   logic [3:0]                      idx_q;
   logic                            pend_vld_q;
   logic [3:0]                      pend_idx_q;
   logic                            crash_q;
   logic [3:0]                      hit_idx_q;

   logic        run, clr, start_acc, scan_step, last_slot;
   logic [19:0] cur_x;
   logic [17:0] cur_y;
   logic        slot_live, ovl_hit, slot_hit, bnd_hit;

   assign run       = (bus.gamemode == GM_RUN);
   assign clr       = (bus.gamemode == GM_IDLE);
   assign start_acc = (state_q == ST_IDLE) && bus.start && run && !crash_q;
   assign scan_step = (state_q == ST_SCAN) && run;
   assign last_slot = (idx_q == 4'(NUM_OBSTACLES - 1));

   assign cur_x     = snap_x_q[idx_q];
   assign cur_y     = snap_y_q[idx_q];
   assign slot_live = ({1'b0, get_left(cur_x)} < 11'(SCREEN_WIDTH));
   assign slot_hit  = slot_live && ovl_hit;
   assign bnd_hit   = (py_q < 9'(UPPER_BOUND)) ||
                      (({1'b0, py_q} + 10'(PLAYER_SIZE_Y)) > 10'(LOWER_BOUND));

   rect_overlap u_ovl (
      .a_l_i (11'(PLAYER_X)),
      .a_r_i (11'(PLAYER_X + PLAYER_SIZE_X)),
      .a_t_i ({2'b0, py_q}),
      .a_b_i ({2'b0, py_q} + 11'(PLAYER_SIZE_Y)),
      .b_l_i ({1'b0, get_left(cur_x)}),
      .b_r_i ({1'b0, get_right(cur_x)}),
      .b_t_i ({2'b0, get_top(cur_y)}),
      .b_b_i ({2'b0, get_bottom(cur_y)}),
      .hit_o (ovl_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (start_acc) state_d = ST_SCAN;
            ST_SCAN:   if (run && last_slot) state_d = ST_REPORT;
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.busy      = (state_q == ST_SCAN);
      bus.done      = (state_q == ST_REPORT);
      bus.crash     = crash_q;
      bus.hit_index = hit_idx_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_x_q   <= {NUM_OBSTACLES{10'(OFFSCREEN_X), 10'(OFFSCREEN_X)}};
         snap_y_q   <= {NUM_OBSTACLES{9'(OFFSCREEN_Y), 9'(OFFSCREEN_Y)}};
         py_q       <= '0;
         idx_q      <= '0;
         pend_vld_q <= 1'b0;
         pend_idx_q <= '0;
         crash_q    <= 1'b0;
         hit_idx_q  <= '0;
      end else if (clr) begin
         idx_q      <= '0;
         pend_vld_q <= 1'b0;
         crash_q    <= 1'b0;
         hit_idx_q  <= '0;
      end else begin
         if (start_acc) begin
            snap_x_q   <= bus.obstacle_x;
            snap_y_q   <= bus.obstacle_y;
            py_q       <= bus.player_y;
            idx_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
         end
         // Only the first hit sticks; the boundary check rides along with slot 0 so it wins.
         if (scan_step) begin
            idx_q <= idx_q + 4'd1;
            if (!pend_vld_q) begin
               if ((idx_q == 4'd0) && bnd_hit) begin
                  pend_vld_q <= 1'b1;
                  pend_idx_q <= HIT_BOUNDARY;
               end else if (slot_hit) begin
                  pend_vld_q <= 1'b1;
                  pend_idx_q <= idx_q;
               end
            end
         end
         if ((state_q == ST_REPORT) && pend_vld_q) begin
            crash_q   <= 1'b1;
            hit_idx_q <= pend_idx_q;
         end
      end
   end

endmodule

// File: tb/tb_collision_detector.sv
// Directed and randomized frame scans checked against a loop-based reference of the hit rules.
module tb_collision_detector;
   import game_pkg::*;

   typedef logic [NUM_OBSTACLES-1:0][19:0] xbus_t;
   typedef logic [NUM_OBSTACLES-1:0][17:0] ybus_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;
   int   mdl_hidx = 0;

   collision_detector_if bus ();

   collision_detector dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [19:0] mkx(input int l, input int r);
      logic [9:0] lv, rv;
      lv = 10'(l);
      rv = 10'(r);
      return {lv, rv};
   endfunction

   function automatic logic [17:0] mky(input int t, input int b);
      logic [8:0] tv, bv;
      tv = 9'(t);
      bv = 9'(b);
      return {tv, bv};
   endfunction

   function automatic void all_sentinel(output xbus_t xa, output ybus_t ya);
      for (int i = 0; i < NUM_OBSTACLES; i++) begin
         xa[i] = mkx(700, 700);
         ya[i] = mky(500, 500);
      end
   endfunction

   // Reference: boundary first, then lowest live slot that strictly overlaps the player box.
   function automatic void ref_scan(input xbus_t xa, input ybus_t ya, input int py,
                                    output bit hit, output int idx);
      int l, r, t, b;
      hit = 0;
      idx = 0;
      if (py < 20 || py + 40 > 460) begin
         hit = 1;
         idx = 15;
         return;
      end
      for (int i = 0; i < NUM_OBSTACLES; i++) begin
         l = int'(xa[i][19:10]);
         r = int'(xa[i][9:0]);
         t = int'(ya[i][17:9]);
         b = int'(ya[i][8:0]);
         if (l >= 640) continue;
         if (80 < r && 120 > l && py < b && py + 40 > t) begin
            hit = 1;
            idx = i;
            return;
         end
      end
   endfunction

   task automatic clear_game();
      bus.gamemode = 2'b00;
      tick();
      mdl_hidx = 0;
      chk("clr_crash", int'(bus.crash), 0);
      chk("clr_hidx", int'(bus.hit_index), 0);
      bus.gamemode = 2'b01;
   endtask

   // One full scan; optional gamemode hold and a mid-scan bus change plus stray start.
   task automatic run_scan(input string tag, input xbus_t xa, input ybus_t ya, input int py,
                           input int hold_at, input int hold_len, input int poke_at);
      bit hit;
      int idx, n;
      ref_scan(xa, ya, py, hit, idx);
      bus.obstacle_x = xa;
      bus.obstacle_y = ya;
      bus.player_y   = 9'(py);
      bus.start      = 1'b1;
      tick();
      n = 1;
      bus.start = 1'b0;
      chk({tag, "_busy"}, int'(bus.busy), 1);
      while (!bus.done && n < 40) begin
         if (n == hold_at) bus.gamemode = 2'b10;
         if (n == hold_at + hold_len) bus.gamemode = 2'b01;
         if (n == poke_at) begin
            for (int i = 0; i < NUM_OBSTACLES; i++) begin
               bus.obstacle_x[i] = mkx(0, 1000);
               bus.obstacle_y[i] = mky(0, 500);
            end
            bus.player_y = 9'd10;
            bus.start    = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         tick();
         n++;
      end
      bus.start = 1'b0;
      chk({tag, "_lat"}, n, 11 + hold_len);
      chk({tag, "_busy_rep"}, int'(bus.busy), 0);
      tick();
      if (hit) mdl_hidx = idx;
      chk({tag, "_done1"}, int'(bus.done), 0);
      chk({tag, "_crash"}, int'(bus.crash), int'(hit));
      chk({tag, "_hidx"}, int'(bus.hit_index), mdl_hidx);
      chk({tag, "_idle"}, int'(bus.busy), 0);
   endtask

   initial begin
      xbus_t xa;
      ybus_t ya;
      int    dones, l, t;

      rst_n          = 1'b0;
      bus.gamemode   = 2'b00;
      bus.start      = 1'b0;
      bus.player_y   = '0;
      all_sentinel(xa, ya);
      bus.obstacle_x = xa;
      bus.obstacle_y = ya;
      tick();
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_crash", int'(bus.crash), 0);
      chk("rst_hidx", int'(bus.hit_index), 0);
      rst_n = 1'b1;
      tick();
      bus.gamemode = 2'b01;
      tick();

      // Slot 3 overlap, then a start while crashed must be ignored
      all_sentinel(xa, ya);
      xa[3] = mkx(100, 140);
      ya[3] = mky(200, 300);
      run_scan("slot3", xa, ya, 250, 0, 0, 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("blocked", int'(bus.busy), 0);
      clear_game();

      xa[3] = mkx(120, 140);
      run_scan("touch", xa, ya, 250, 0, 0, 0);

      all_sentinel(xa, ya);
      xa[2] = mkx(90, 110);  ya[2] = mky(240, 260);
      xa[7] = mkx(60, 200);  ya[7] = mky(100, 400);
      run_scan("two", xa, ya, 250, 0, 0, 0);
      clear_game();

      all_sentinel(xa, ya);
      run_scan("bnd_top", xa, ya, 10, 0, 0, 0);
      clear_game();
      run_scan("bnd_edge", xa, ya, 420, 0, 0, 0);
      run_scan("bnd_bot", xa, ya, 421, 0, 0, 0);
      clear_game();

      // Boundary beats an obstacle hit in slot 0
      xa[0] = mkx(70, 130); ya[0] = mky(0, 60);
      run_scan("bnd_pri", xa, ya, 15, 0, 0, 0);
      clear_game();

      // Freeze for 3 cycles mid-scan
      all_sentinel(xa, ya);
      xa[5] = mkx(100, 140); ya[5] = mky(200, 300);
      run_scan("hold", xa, ya, 250, 4, 3, 0);
      clear_game();

      // Snapshot isolation: bus goes all-hit and start pulses mid-scan
      all_sentinel(xa, ya);
      run_scan("snap", xa, ya, 250, 0, 0, 4);

      // Abort with gamemode 00 at T+5
      all_sentinel(xa, ya);
      xa[3] = mkx(100, 140); ya[3] = mky(200, 300);
      bus.obstacle_x = xa;
      bus.obstacle_y = ya;
      bus.player_y   = 9'd250;
      bus.start      = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (4) tick();
      bus.gamemode = 2'b00;
      tick();
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_crash", int'(bus.crash), 0);
      bus.gamemode = 2'b01;
      dones = 0;
      repeat (15) begin
         tick();
         if (bus.done) dones++;
      end
      chk("abort_nodone", dones, 0);
      chk("abort_crash2", int'(bus.crash), 0);
      mdl_hidx = 0;

      // Randomized frames
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < NUM_OBSTACLES; i++) begin
            if ($urandom_range(0, 2) == 0) begin
               xa[i] = mkx(700, 700);
               ya[i] = mky(500, 500);
            end else begin
               l = int'($urandom_range(0, 700));
               t = int'($urandom_range(0, 480));
               xa[i] = mkx(l, (l + int'($urandom_range(0, 120)) > 1023) ? 1023 : l + int'($urandom_range(0, 120)));
               ya[i] = mky(t, (t + int'($urandom_range(0, 120)) > 511) ? 511 : t + int'($urandom_range(0, 120)));
            end
         end
         run_scan("rnd", xa, ya, int'($urandom_range(0, 480)), 0, 0, 0);
         if (bus.crash) clear_game();
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
